edge_event_arbiter: RTL and testbench

//  Multi-channel edge-event scheduler. Watches N_CH level inputs and detects rising

---
 rtl/edge_event_arbiter.sv | 175 +++++++++++++++++
 tb/tb_edge_event_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
//   Multi-channel edge-event scheduler. Rising edges on N_CH synchronised level
//   inputs are latched as per-channel pending flags and handed to one consumer
//   over a valid/ready port, one event per accept, with round-robin arbitration.
//
// Parameters
//   N_CH       number of level channels (2..16)
//   CH_W       channel index width, equal to clog2(N_CH)
//
// Ports
//   clk        clock, all logic on posedge
//   reset      synchronous active-high reset
//   level      synchronised level inputs, one per channel
//   evt_valid  event offered to the consumer
//   evt_ready  consumer accepts when evt_valid & evt_ready
//   evt_ch     channel index of the offered event
//   evt_pol    1 = rising edge, 0 = falling edge
//   overflow   sticky per channel: edge arrived while that channel was pending
//   clr_ovf    one-cycle pulse clearing all overflow bits
//
// Build option
//   EDGE_ARB_BOTH_EDGES_EN  when defined, falling edges are events too and the
//                           per-channel edge polarity is stored and reported on
//                           evt_pol. Otherwise evt_pol is tied to 1.

module edge_event_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] level,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_pol,
  output logic [N_CH-1:0] overflow,
  input  logic            clr_ovf
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t          state;
  logic [N_CH-1:0] prev_level;
  logic [N_CH-1:0] pending;
  logic [CH_W-1:0] rr_ptr;

  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] edge_any;
  logic            accept;
  logic [N_CH-1:0] acc_mask;
  logic [N_CH-1:0] pend_kept;
  logic [N_CH-1:0] pending_nxt;
  logic [N_CH-1:0] overflow_nxt;
  logic [CH_W-1:0] rr_next;
  logic [CH_W:0]   idle_pick;
  logic [CH_W:0]   acc_pick;

  // Returns {found, index} of the first set bit of req at or above start,
  // wrapping modulo N_CH.
  function automatic logic [CH_W:0] rr_pick(input logic [N_CH-1:0] req,
                                            input logic [CH_W-1:0] start);
    logic            found;
    logic [CH_W-1:0] idx;
    logic [CH_W-1:0] kk;
    int              k;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      k = int'(start) + i;
      if (k >= N_CH) k = k - N_CH;
      kk = CH_W'(k);
      if (!found && req[kk]) begin
        found = 1'b1;
        idx   = kk;
      end
    end
    return {found, idx};
  endfunction

  assign rise = level & ~prev_level;

`ifdef EDGE_ARB_BOTH_EDGES_EN
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] pend_pol;
  logic [N_CH-1:0] pend_pol_nxt;
  logic            evt_pol_q;

  assign fall     = ~level & prev_level;
  assign edge_any = rise | fall;
  assign evt_pol  = evt_pol_q;
`else
  assign edge_any = rise;
  assign evt_pol  = 1'b1;
`endif

  assign accept   = (state == OFFER) && evt_ready;
  assign acc_mask = accept ? (N_CH'(1) << evt_ch) : '0;

  // A new edge on the channel being accepted re-arms it (set wins) and is
  // not an overflow; an edge on any other still-pending channel is.
  assign pend_kept    = pending & ~acc_mask;
  assign pending_nxt  = pend_kept | edge_any;
  assign overflow_nxt = (clr_ovf ? '0 : overflow) | (edge_any & pend_kept);

  assign rr_next   = (evt_ch == CH_W'(N_CH - 1)) ? '0 : evt_ch + 1'b1;
  assign idle_pick = rr_pick(pending, rr_ptr);
  assign acc_pick  = rr_pick(pending & ~acc_mask, rr_next);

`ifdef EDGE_ARB_BOTH_EDGES_EN
  // Polarity is captured only when a flag goes from clear to set; an
  // overflowing edge leaves the stored polarity alone.
  always_comb begin
    pend_pol_nxt = pend_pol;
    for (int i = 0; i < N_CH; i++) begin
      if (edge_any[i] && !pend_kept[i]) pend_pol_nxt[i] = rise[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_pol  <= '1;
      evt_pol_q <= 1'b1;
    end else begin
      pend_pol <= pend_pol_nxt;
      if (state == IDLE && idle_pick[CH_W])
        evt_pol_q <= pend_pol[idle_pick[CH_W-1:0]];
      else if (accept && acc_pick[CH_W])
        evt_pol_q <= pend_pol[acc_pick[CH_W-1:0]];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_level <= '0;
      pending    <= '0;
      overflow   <= '0;
      rr_ptr     <= '0;
      state      <= IDLE;
      evt_valid  <= 1'b0;
      evt_ch     <= '0;
    end else begin
      prev_level <= level;
      pending    <= pending_nxt;
      overflow   <= overflow_nxt;
      case (state)
        IDLE: begin
          if (idle_pick[CH_W]) begin
            evt_ch    <= idle_pick[CH_W-1:0];
            evt_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          // Offer is held stable until accepted; no preemption.
          if (evt_ready) begin
            rr_ptr <= rr_next;
            if (acc_pick[CH_W]) begin
              evt_ch <= acc_pick[CH_W-1:0];
            end else begin
              evt_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          evt_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
module tb_edge_event_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] level;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic       evt_pol;
  logic [3:0] overflow;
  logic       clr_ovf;

  int n_chk;
  int n_pass;
  int n_fail;

  edge_event_arbiter #(.N_CH(4), .CH_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .level     (level),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_pol   (evt_pol),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    level     = 4'b0000;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    n_fail = 0;

    // 1: reset state and single-edge latency
    do_reset();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_ch",    32'(evt_ch),    32'd0);
    chk("rst_pol",   32'(evt_pol),   32'd1);
    chk("rst_ovf",   32'(overflow),  32'd0);
    level = 4'b0100;
    tick();
    chk("t1_valid_T1", 32'(evt_valid), 32'd0);
    tick();
    chk("t1_valid_T2", 32'(evt_valid), 32'd1);
    chk("t1_ch_T2",    32'(evt_ch),    32'd2);
    chk("t1_pol_T2",   32'(evt_pol),   32'd1);
    evt_ready = 1'b1;
    tick();
    chk("t1_valid_T3", 32'(evt_valid), 32'd0);

    // 2: all four channels at once, back-to-back delivery
    do_reset();
    level     = 4'b1111;
    evt_ready = 1'b1;
    tick();
    chk("t2_valid_pre", 32'(evt_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t2_valid_%0d", i), 32'(evt_valid), 32'd1);
      chk($sformatf("t2_ch_%0d", i),    32'(evt_ch),    32'(i));
    end
    tick();
    chk("t2_valid_end", 32'(evt_valid), 32'd0);

    // 3: stalled offer, overflow, clear vs set priority
    do_reset();
    level = 4'b0010;
    tick();
    tick();
    chk("t3_valid", 32'(evt_valid), 32'd1);
    chk("t3_ch",    32'(evt_ch),    32'd1);
    level = 4'b0000;
    tick();
    level = 4'b0010;
    tick();
    chk("t3_ovf_set",  32'(overflow),  32'h2);
    chk("t3_ch_held",  32'(evt_ch),    32'd1);
    chk("t3_vld_held", 32'(evt_valid), 32'd1);
    level = 4'b0000;
    tick();
    level   = 4'b0010;
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_set_wins", 32'(overflow), 32'h2);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_ovf_clr",  32'(overflow), 32'h0);
    chk("t3_ch_held2", 32'(evt_ch),   32'd1);
    evt_ready = 1'b1;
    tick();
    chk("t3_drained", 32'(evt_valid), 32'd0);

    // 4: round-robin resumes after the accepted channel
    do_reset();
    level = 4'b0100;
    tick();
    tick();
    chk("t4_ch2", 32'(evt_ch), 32'd2);
    level = 4'b1101;
    tick();
    chk("t4_no_preempt", 32'(evt_ch), 32'd2);
    evt_ready = 1'b1;
    tick();
    chk("t4_first_ch3", 32'(evt_ch), 32'd3);
    tick();
    chk("t4_then_ch0", 32'(evt_ch), 32'd0);
    chk("t4_then_vld", 32'(evt_valid), 32'd1);
    tick();
    chk("t4_idle", 32'(evt_valid), 32'd0);

    // edge on the channel being accepted re-arms it without overflow
    do_reset();
    level = 4'b0001;
    tick();
    tick();
    chk("rearm_ch0", 32'(evt_ch), 32'd0);
    level = 4'b0000;
    tick();
    level     = 4'b0001;
    evt_ready = 1'b1;
    tick();
    chk("rearm_valid0", 32'(evt_valid), 32'd0);
`ifdef EDGE_ARB_BOTH_EDGES_EN
    chk("rearm_ovf", 32'(overflow), 32'h1);
`else
    chk("rearm_ovf", 32'(overflow), 32'h0);
`endif
    tick();
    chk("rearm_valid1", 32'(evt_valid), 32'd1);
    chk("rearm_ch",     32'(evt_ch),    32'd0);
    chk("rearm_pol",    32'(evt_pol),   32'd1);

    // 5: reset while offering, levels held high across release
    do_reset();
    level = 4'b0111;
    tick();
    tick();
    chk("t5_offer", 32'(evt_valid), 32'd1);
    reset = 1'b1;
    tick();
    chk("t5_rst_valid", 32'(evt_valid), 32'd0);
    chk("t5_rst_ovf",   32'(overflow),  32'd0);
    reset = 1'b0;
    tick();
    chk("t5_rel1_valid", 32'(evt_valid), 32'd0);
    tick();
    chk("t5_rel2_valid", 32'(evt_valid), 32'd1);
    chk("t5_rel2_ch",    32'(evt_ch),    32'd0);
    chk("t5_rel2_ovf",   32'(overflow),  32'd0);

    // 6: falling edge
    do_reset();
    level = 4'b0001;
    tick();
    tick();
    evt_ready = 1'b1;
    tick();
    chk("t6_accepted", 32'(evt_valid), 32'd0);
    level = 4'b0000;
    tick();
    tick();
`ifdef EDGE_ARB_BOTH_EDGES_EN
    chk("t6_valid", 32'(evt_valid), 32'd1);
    chk("t6_ch",    32'(evt_ch),    32'd0);
    chk("t6_pol",   32'(evt_pol),   32'd0);
`else
    chk("t6_valid", 32'(evt_valid), 32'd0);
    chk("t6_pol",   32'(evt_pol),   32'd1);
`endif
    tick();
    chk("t6_end", 32'(evt_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
